window_3x3_reader: RTL and testbench
====================================

# window_3x3_reader

Consumer-side controller for the 256x256 pixel FIFO in the median filter datapath. It drains one image frame from the FIFO in raster order through the FIFO's enable/push-pop control pins, keeps the two previous rows in line buffers, and emits one 3x3 neighbourhood per interior pixel to the median sorting stage through a valid/ready handshake. Only interior centres produce windows; border pixels produce none.

## Interface
- DATA_WIDTH, 8, pixel width
- IMG_W, 256, pixels per row (>= 3)
- IMG_H, 256, rows per frame (>= 3)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to read a frame; honoured in IDLE only
- fifo_en  out  1  FIFO enable; high means pop this cycle
- fifo_push_pop  out  1  FIFO direction; constant 0 (pop)
- fifo_data  in  DATA_WIDTH  FIFO data output, valid combinationally for the current read pointer
- fifo_empty  in  1  FIFO empty flag
- win_valid  out  1  window available
- win_ready  in  1  downstream accepts the window
- win_out  out  9*DATA_WIDTH  tap k at [k*DATA_WIDTH +: DATA_WIDTH], k = 3*dr + dc, dr/dc in 0..2 relative to (row-2, col-2); k=4 is the centre
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last window is accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: if start is high, go to RUN and clear row/col to 0. Otherwise stay in IDLE.
- RUN: pop = !fifo_empty && (!win_valid || win_ready). fifo_en = pop, driven combinationally. fifo_en is never high outside RUN.
- On a pop, the pixel at (row, col) is fifo_data, sampled at the same edge. At that edge:
  - lb1[col] <= lb0[col], lb0[col] <= fifo_data (line buffers, combinational read, synchronous write).
  - The window shifts left one column. The new right column is {lb1[col], lb0[col], fifo_data}, top to bottom.
  - col increments. At IMG_W-1, col wraps to 0 and row increments.
- win_valid update:
  - On a pop, win_valid <= (row >= 2 && col >= 2).
  - On no pop with win_ready, win_valid <= 0.
  - Otherwise win_valid holds, and win_out stays stable while win_valid && !win_ready.
- The pop of (IMG_H-1, IMG_W-1) moves the state to DRAIN.
- DRAIN: once the final window handshakes (win_valid && win_ready), done pulses and the state returns to IDLE.
- Windows per frame: (IMG_W-2)*(IMG_H-2) = 64516 at the defaults.
- start outside IDLE is ignored.
- Simultaneous win_ready and pop: the old window is accepted and the new one loads at the same edge (full throughput, 1 window/cycle).
- Empty FIFO: no pop, and row/col/window hold. A mid-row stall does not corrupt the window.

## Timing
- Reset values: state IDLE, row=0, col=0, win_valid=0, win_out=0, done=0, busy=0, fifo_en=0, fifo_push_pop=0.
- Line buffer contents are not reset. Stale data is masked because no window is emitted while row < 2.
- Latency: win_valid rises the cycle after the pop of pixel (r, c) with r,c >= 2. That window has centre (r-1, c-1).
- Reset mid-frame: the next cycle is the full reset state; no done pulse. A following start reads a fresh frame with row/col at 0.
- Counter widths: row is clog2(IMG_H) bits, col is clog2(IMG_W) bits. Compares are exact, with no overflow wrap past the frame.

## Structure
- Package median_pkg holds DATA_WIDTH, IMG_W, IMG_H, WIN_TAPS = 9, and the state enum {IDLE, RUN, DRAIN}. The FIFO and the sorter share this package.
- Sub-module line_buffer: IMG_W x DATA_WIDTH, combinational read at addr, synchronous write on we. The block instantiates it twice (lb0, lb1).
- The window registers, counters and FSM live in window_3x3_reader.

## Test plan
- Reset: assert reset 3 cycles mid-stimulus. All outputs are at reset values, and fifo_en stays 0 with fifo_empty=0.
- 4x4 frame (IMG_W=IMG_H=4), pixels 0..15, win_ready=1:
  - exactly 4 windows;
  - first window taps {0,1,2,4,5,6,8,9,10}, valid the cycle after the pop of pixel 10;
  - last window taps {5,6,7,9,10,11,13,14,15};
  - done is a single pulse.
- Empty gaps: toggle fifo_empty randomly during the 4x4 frame. fifo_en is never high while empty, and the window sequence is identical to the gap-free run.
- Backpressure: drop win_ready for 5 cycles while win_valid=1. win_out is bit-stable, fifo_en stays 0, no window is lost or duplicated, and the count stays 4.
- Mid-frame reset: reset after pixel 7, then start a new frame. The output equals a clean run, with no window mixing data from the two frames.
- Full default frame with random ready:
  - 64516 windows, each matching a reference model;
  - start pulses during RUN are ignored;
  - busy falls together with done.

Source files
------------

// File: rtl/median_pkg.sv
// median_pkg: shared image geometry, window size and reader state encoding for the median filter datapath
package median_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int IMG_W      = 256;
    localparam int IMG_H      = 256;
    localparam int WIN_TAPS   = 9;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/window_3x3_reader_if.sv
// window_3x3_reader_if: FIFO pop port and window valid/ready stream of the 3x3 window reader
interface window_3x3_reader_if #(
    parameter int DATA_WIDTH = median_pkg::DATA_WIDTH
);
    logic                                      fifo_en;
    logic                                      fifo_push_pop;
    logic [DATA_WIDTH-1:0]                     fifo_data;
    logic                                      fifo_empty;
    logic                                      win_valid;
    logic                                      win_ready;
    logic [median_pkg::WIN_TAPS*DATA_WIDTH-1:0] win_out;
    modport master (
        output fifo_en, fifo_push_pop, win_valid, win_out,
        input  fifo_data, fifo_empty, win_ready
    );
    modport slave (
        input  fifo_en, fifo_push_pop, win_valid, win_out,
        output fifo_data, fifo_empty, win_ready
    );
endinterface

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels, combinational read and synchronous write at a shared address
module line_buffer
    import median_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    // Overwrite the column entry with the pixel arriving for that column
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/window_3x3_reader.sv
// window_3x3_reader: drains a frame from the pixel FIFO and streams the 3x3 neighbourhood of every interior pixel
module window_3x3_reader
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = median_pkg::DATA_WIDTH,
    parameter int IMG_W      = median_pkg::IMG_W,
    parameter int IMG_H      = median_pkg::IMG_H
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    window_3x3_reader_if.master bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);
    localparam logic [CW-1:0] COL_FIRST = CW'(2);

    state_t                           state_q, state_d;
    logic [RW-1:0]                    row_q, row_d;
    logic [CW-1:0]                    col_q, col_d;
    logic                             win_valid_q, win_valid_d;
    logic [WIN_TAPS*DATA_WIDTH-1:0]   win_q, win_d;
    logic                             done_q, done_d;
    logic                             pop, last_pix, col_wrap;
    logic [DATA_WIDTH-1:0]            lb0_rd, lb1_rd;

    // A pop needs data and room: the window register is free or being accepted this cycle
    assign pop      = (state_q == RUN) && !bus.fifo_empty && (!win_valid_q || bus.win_ready);
    assign col_wrap = col_q == COL_LAST;
    assign last_pix = (row_q == ROW_LAST) && col_wrap;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH)) lb0 (
        .clk     (clk),
        .we_i    (pop),
        .addr_i  (col_q),
        .wdata_i (bus.fifo_data),
        .rdata_o (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH)) lb1 (
        .clk     (clk),
        .we_i    (pop),
        .addr_i  (col_q),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Next state: frame sequencing, raster counters and the sliding window
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_d       = win_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN:     state_d = (pop && last_pix) ? DRAIN : RUN;
            DRAIN: begin
                if (win_valid_q && bus.win_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            col_d       = col_wrap ? '0 : col_q + 1'b1;
            row_d       = last_pix ? '0 : (col_wrap ? row_q + 1'b1 : row_q);
            win_valid_d = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            for (int r = 0; r < 3; r++) begin
                win_d[(3*r)*DATA_WIDTH +: DATA_WIDTH]   = win_q[(3*r+1)*DATA_WIDTH +: DATA_WIDTH];
                win_d[(3*r+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[(3*r+2)*DATA_WIDTH +: DATA_WIDTH];
            end
            win_d[2*DATA_WIDTH +: DATA_WIDTH] = lb1_rd;
            win_d[5*DATA_WIDTH +: DATA_WIDTH] = lb0_rd;
            win_d[8*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset to an idle, empty reader
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
            done_q      <= done_d;
        end
    end

    assign bus.fifo_en       = pop;
    assign bus.fifo_push_pop = 1'b0;
    assign bus.win_valid     = win_valid_q;
    assign bus.win_out       = win_q;
    assign busy              = state_q != IDLE;
    assign done              = done_q;
endmodule

// File: tb/tb_window_3x3_reader.sv
// tb_window_3x3_reader: directed checks of the 3x3 window reader on a 4x4 frame and a full default frame
module tb_window_3x3_reader;
    import median_pkg::*;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic start_s = 1'b0;
    logic start_l = 1'b0;
    logic ready_s = 1'b1;
    logic ready_l = 1'b1;
    logic gap_s   = 1'b0;
    logic busy_s, done_s, busy_l, done_l;
    int ptr_s = 0, ptr_l = 0, n_s = 0, n_l = 0;
    int n_assert = 0, n_fail = 0;
    logic [71:0] last_s = '0;

    localparam logic [71:0] FIRST_WIN = 72'h0A_09_08_06_05_04_02_01_00;
    localparam logic [71:0] LAST_WIN  = 72'h0F_0E_0D_0B_0A_09_07_06_05;

    window_3x3_reader_if #(.DATA_WIDTH(8)) bus_s ();
    window_3x3_reader_if #(.DATA_WIDTH(8)) bus_l ();

    window_3x3_reader #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s), .bus(bus_s)
    );
    window_3x3_reader #(.DATA_WIDTH(8), .IMG_W(256), .IMG_H(256)) dut_l (
        .clk(clk), .reset(reset), .start(start_l), .busy(busy_l), .done(done_l), .bus(bus_l)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pl(input int r, input int c);
        return 8'((r * 37 + c * 11 + (r / 4) * c) % 256);
    endfunction

    function automatic logic [71:0] exp_win(input int w, input int n, input bit big);
        logic [71:0] v = '0;
        int cr = 1 + n / (w - 2);
        int cc = 1 + n % (w - 2);
        for (int k = 0; k < 9; k++)
            v[k*8 +: 8] = big ? pl(cr - 1 + k / 3, cc - 1 + k % 3)
                              : 8'((cr - 1 + k / 3) * w + cc - 1 + k % 3);
        return v;
    endfunction

    assign bus_s.fifo_data  = ptr_s < 16 ? 8'(ptr_s) : 8'h00;
    assign bus_s.fifo_empty = gap_s || ptr_s >= 16;
    assign bus_s.win_ready  = ready_s;
    assign bus_l.fifo_data  = pl(ptr_l / 256, ptr_l % 256);
    assign bus_l.fifo_empty = ptr_l >= 65536;
    assign bus_l.win_ready  = ready_l;

    always @(posedge clk) begin
        if (reset || start_s) ptr_s <= 0;
        else if (bus_s.fifo_en) ptr_s <= ptr_s + 1;
        if (reset) ptr_l <= 0;
        else if (bus_l.fifo_en) ptr_l <= ptr_l + 1;
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset || start_s) n_s = 0;
        else if (bus_s.win_valid && bus_s.win_ready) begin
            check("win_s", bus_s.win_out, exp_win(4, n_s, 1'b0));
            last_s = bus_s.win_out;
            n_s++;
        end
        if (bus_s.fifo_empty) check("en_while_empty", 72'(bus_s.fifo_en), 72'd0);
        if (reset) n_l = 0;
        else if (bus_l.win_valid && bus_l.win_ready) begin
            check("win_l", bus_l.win_out, exp_win(256, n_l, 1'b1));
            n_l++;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, 72'(busy_s), 72'd0);
        check({tag, "_done"}, 72'(done_s), 72'd0);
        check({tag, "_valid"}, 72'(bus_s.win_valid), 72'd0);
        check({tag, "_win_out"}, bus_s.win_out, 72'd0);
        check({tag, "_fifo_en"}, 72'(bus_s.fifo_en), 72'd0);
        check({tag, "_push_pop"}, 72'(bus_s.fifo_push_pop), 72'd0);
        check({tag, "_busy_l"}, 72'(busy_l), 72'd0);
        check({tag, "_fifo_en_l"}, 72'(bus_l.fifo_en), 72'd0);
    endtask

    task automatic reset3(input string tag);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            reset_checks(tag);
        end
        #1 reset = 1'b0;
    endtask

    task automatic run_s(input bit gaps, input bit bp, input string tag);
        int  stall = 0;
        bit  seen = 1'b0, p10 = 1'b0, prev_busy = 1'b0;
        ready_s = !bp;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            gap_s = gaps && ($urandom_range(0, 2) == 0);
            if (bp && stall == 5) ready_s = 1'b1;
            @(negedge clk);
            if (p10) begin
                check({tag, "_first_valid"}, 72'(bus_s.win_valid), 72'd1);
                check({tag, "_first_taps"}, bus_s.win_out, FIRST_WIN);
                p10 = 1'b0;
            end
            if (bus_s.fifo_en) check({tag, "_push_pop"}, 72'(bus_s.fifo_push_pop), 72'd0);
            if (bus_s.fifo_en && bus_s.fifo_data == 8'd10) begin
                check({tag, "_pre_valid"}, 72'(bus_s.win_valid), 72'd0);
                p10 = 1'b1;
            end
            if (bp && stall < 5 && bus_s.win_valid) begin
                check({tag, "_hold_taps"}, bus_s.win_out, FIRST_WIN);
                check({tag, "_hold_no_pop"}, 72'(bus_s.fifo_en), 72'd0);
                stall++;
            end
            if (done_s) begin
                check({tag, "_busy_fall"}, 72'({prev_busy, busy_s}), 72'b10);
                seen = 1'b1;
            end
            prev_busy = busy_s;
            @(posedge clk); #1;
        end
        gap_s   = 1'b0;
        ready_s = 1'b1;
        check({tag, "_done_seen"}, 72'(seen), 72'd1);
        check({tag, "_count"}, 72'(n_s), 72'd4);
        check({tag, "_last_taps"}, last_s, LAST_WIN);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_done_single"}, 72'(done_s), 72'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit hit = 1'b0, seen = 1'b0, prev_busy = 1'b0;
        reset3("rst_init");
        run_s(1'b0, 1'b0, "clean");
        run_s(1'b1, 1'b0, "gaps");
        run_s(1'b0, 1'b1, "bp");
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (bus_s.fifo_en && bus_s.fifo_data == 8'd7) hit = 1'b1;
            @(posedge clk); #1;
        end
        check("pix7_popped", 72'(hit), 72'd1);
        reset3("rst_mid");
        run_s(1'b0, 1'b0, "post_rst");
        @(posedge clk); #1 start_l = 1'b1;
        @(posedge clk); #1 start_l = 1'b0;
        for (int i = 0; i < 90000 && !seen; i++) begin
            ready_l = $urandom_range(0, 31) != 0;
            start_l = (i == 100 || i == 40000);
            @(negedge clk);
            if (i == 100 || i == 40000) check("big_busy_at_start", 72'(busy_l), 72'd1);
            if (done_l) begin
                check("big_busy_fall", 72'({prev_busy, busy_l}), 72'b10);
                seen = 1'b1;
            end
            prev_busy = busy_l;
            @(posedge clk); #1;
        end
        start_l = 1'b0;
        ready_l = 1'b1;
        check("big_done_seen", 72'(seen), 72'd1);
        check("big_count", 72'(n_l), 72'd64516);
        @(negedge clk);
        check("big_done_single", 72'(done_l), 72'd0);
        check("big_idle", 72'(busy_l), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
